// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared FSM state type and sampling helpers for uart_rx_os.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic int half_bit_cnt(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  function automatic int bit_cnt_w(input int clks_per_bit);
    return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous show-ahead FIFO; a push while full is accepted
//               only when a pop frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]     count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == NW'(FIFO_DEPTH));
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os
// Description : Oversampling UART receiver with mid-bit sampling, optional
//               parity (macro UART_RX_PARITY_EN), 1/2 stop bits, error pulses
//               and a show-ahead receive FIFO with valid/ready drain.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
  import uart_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = bit_cnt_w(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] c_half_m1 = CW'(half_bit_cnt(CLKS_PER_BIT) - 1);
  localparam logic [CW-1:0] c_full_m1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] c_data_last = BW'(DATA_W - 1);
  localparam logic [BW-1:0] c_stop_last = BW'(STOP_BITS - 1);
  localparam logic          c_par_odd   = (PARITY_ODD != 0);
`ifdef UART_RX_PARITY_EN
  localparam logic          c_par_en    = 1'b1;
`else
  localparam logic          c_par_en    = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_bad_q, par_bad_d;
  logic              stop_bad_q, stop_bad_d;
  logic              armed_q, armed_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overrun_q, overrun_d;

  logic rx_s;
  logic sample;
  logic stop_done;
  logic stop_low;
  logic par_fail;
  logic push_req;
  logic pop_req;
  logic fifo_full;
  logic fifo_empty;

  assign rx_s    = sync_q[1];
  assign sync_d  = {sync_q[0], rx};
  assign sample  = (state_q == ST_START) ? (cnt_q == c_half_m1) : (cnt_q == c_full_m1);
  assign pop_req = rx_ready & ~fifo_empty;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (armed_q && !rx_s) state_d = ST_START;
        ST_START:  if (sample) state_d = rx_s ? ST_IDLE : ST_DATA;
        ST_DATA:   if (sample && idx_q == c_data_last) state_d = c_par_en ? ST_PARITY : ST_STOP;
        ST_PARITY: if (sample) state_d = ST_STOP;
        ST_STOP:   if (sample && idx_q == c_stop_last) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and frame outcome
  always_comb begin
    busy         = (state_q != ST_IDLE);
    stop_done    = enable & (state_q == ST_STOP) & sample & (idx_q == c_stop_last);
    stop_low     = stop_bad_q | ~rx_s;
    par_fail     = c_par_en & par_bad_q;
    frame_err_d  = stop_done & stop_low;
    parity_err_d = stop_done & ~stop_low & par_fail;
    push_req     = stop_done & ~stop_low & ~par_fail;
    overrun_d    = push_req & fifo_full & ~pop_req;
  end

  // Bit timing, shifter and per-frame error accumulation
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    armed_d    = armed_q;
    if (state_q == ST_IDLE || sample) cnt_d = '0;
    if (state_d != state_q) begin
      idx_d = '0;
    end else if (sample && (state_q == ST_DATA || state_q == ST_STOP)) begin
      idx_d = idx_q + 1'b1;
    end
    if (state_q == ST_DATA && sample) shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
    if (state_q == ST_IDLE) begin
      par_bad_d  = 1'b0;
      stop_bad_d = 1'b0;
    end
    if (state_q == ST_PARITY && sample) par_bad_d = rx_s ^ (^shreg_q) ^ c_par_odd;
    if (state_q == ST_STOP && sample) stop_bad_d = stop_bad_q | ~rx_s;
    // A low stop bit may be a break; wait for the line to idle before re-arming.
    if (frame_err_d) begin
      armed_d = 1'b0;
    end else if (state_q == ST_IDLE && rx_s) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      armed_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      armed_q      <= armed_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign rx_valid   = ~fifo_empty;

  uart_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .wr_data (shreg_q),
    .pop     (pop_req),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os
// Description : Self-checking bench for uart_rx_os (frame table + corner
//               sequences, scoreboard on the FIFO drain side).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

  localparam int DW    = 8;
  localparam int CPB   = 16;
  localparam int HB    = CPB / 2;
  localparam int SB    = 1;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PEN  = 1;
  localparam int PODD = 1;
`else
  localparam int PEN  = 0;
  localparam int PODD = 0;
`endif
  localparam int EXP_LAT = 3 + HB + (DW + PEN + SB) * CPB;

  typedef struct {
    logic [7:0] data;
    bit         par_good;
    bit         stop_ok;
    bit         exp_push;
    bit         exp_ferr;
    bit         exp_perr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          rx;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         ovr_cnt = 0;
  int         rise_cyc = -1;
  int         start_cyc = 0;
  int         f0, p0, o0, lat;
  bit         valid_prev = 1'b0;
  bit         busy_seen = 1'b0;
  logic [7:0] exp_w;
  logic [7:0] exp_q[$];
  vec_t       vecs[$];

  always #5 clk = ~clk;

  uart_rx_os #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB),
    .PARITY_ODD   (PODD),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level so frames can be chained.
  task automatic send_frame(input logic [7:0] d, input bit par_good, input bit stop_ok);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (PEN != 0) send_bit((^d) ^ (PODD != 0) ^ !par_good);
    for (int k = 0; k < SB; k++) send_bit(stop_ok);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    f0 = ferr_cnt;
    p0 = perr_cnt;
    o0 = ovr_cnt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;

    fork
      forever @(posedge clk) cyc++;
      forever begin
        @(negedge clk);
        #1;
        if (frame_err)  ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (overrun)    ovr_cnt++;
        if (busy)       busy_seen = 1'b1;
        if (rx_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = rx_valid;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got 0x%0h expected no word", rx_data);
          end else begin
            exp_w = exp_q.pop_front();
            check("sb_data", 32'(rx_data), 32'(exp_w));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_perr", 32'(parity_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    rst = 1'b0;
    idle(4);

    // 0x99 frame with latency measured from the line edge
    snap();
    rise_cyc = -1;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b1);
    idle(4);
    lat = rise_cyc - start_cyc;
    checks++;
    if (rise_cyc < 0 || lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
      errors++;
      $display("FAIL lat_0x99: got %0d cycles expected %0d", lat, EXP_LAT);
    end
    check("lat_errs", 32'(ferr_cnt - f0 + perr_cnt - p0 + ovr_cnt - o0), 0);
    check("lat_drain", 32'(exp_q.size()), 0);

    vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
`endif
    foreach (vecs[i]) begin
      snap();
      if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].par_good, vecs[i].stop_ok);
      idle(CPB);
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_perr", i), 32'(perr_cnt - p0), 32'(vecs[i].exp_perr));
      check($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - o0), 0);
      check($sformatf("vec%0d_drain", i), 32'(exp_q.size()), 0);
    end

    // false start: short low glitch
    snap();
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    check("fs_busy_seen", 32'(busy_seen), 1);
    check("fs_errs", 32'(ferr_cnt - f0 + perr_cnt - p0), 0);
    check("fs_valid", 32'(rx_valid), 0);

    // bad stop then line held low: receiver must stay disarmed
    snap();
    send_frame(8'h55, 1'b1, 1'b0);
    busy_seen = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("brk_busy", 32'(busy_seen), 0);
    check("brk_ferr", 32'(ferr_cnt - f0), 1);
    idle(CPB);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(CPB);
    check("brk_ferr_once", 32'(ferr_cnt - f0), 1);
    check("brk_drain", 32'(exp_q.size()), 0);

    // overrun: five chained frames into a 4-entry FIFO
    snap();
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b1);
    end
    idle(CPB);
    check("ovr_pulse", 32'(ovr_cnt - o0), 1);
    check("ovr_valid", 32'(rx_valid), 1);
    check("ovr_held", 32'(exp_q.size()), DEPTH);
    rx_ready = 1'b1;
    idle(10);
    check("ovr_drain", 32'(exp_q.size()), 0);
    check("ovr_empty", 32'(rx_valid), 0);

    // enable dropped during data bit 4
    snap();
    fork
      send_frame(8'hAA, 1'b1, 1'b1);
      begin
        repeat (85) @(negedge clk);
        check("abt_busy_pre", 32'(busy), 1);
        enable = 1'b0;
        @(negedge clk);
        #1;
        check("abt_busy_post", 32'(busy), 0);
      end
    join
    idle(CPB);
    enable = 1'b1;
    idle(4);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(CPB);
    check("abt_errs", 32'(ferr_cnt - f0 + perr_cnt - p0), 0);
    check("abt_drain", 32'(exp_q.size()), 0);

    // asynchronous reset mid-frame with a word waiting in the FIFO
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b1);
    idle(4);
    check("rr_pre_valid", 32'(rx_valid), 1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("rr_pre_busy", 32'(busy), 1);
    #3;
    rst = 1'b1;
    #1;
    check("rr_valid", 32'(rx_valid), 0);
    check("rr_busy", 32'(busy), 0);
    check("rr_data", 32'(rx_data), 0);
    check("rr_flags", 32'({frame_err, parity_err, overrun}), 0);
    exp_q.delete();
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(4);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b1);
    idle(CPB);
    check("rr_drain", 32'(exp_q.size()), 0);
    check("rr_empty", 32'(rx_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
